// File: rtl/enc_pkg.sv
// Shared definitions for the encrypter front end: block widths and the
// gearbox FSM state type.
package enc_pkg;

    localparam int PLAIN_W  = 60;
    localparam int CIPHER_W = 78;
    localparam int IN_W     = 8;

    typedef logic [PLAIN_W-1:0] plain_blk_t;

    typedef enum logic {
        ACCUM = 1'b0,
        FLUSH = 1'b1
    } gb_state_t;

endpackage

// File: rtl/enc_block_gearbox_if.sv
// Byte-in / block-out stream bundle for enc_block_gearbox.
//
// Handshake: a transfer happens on a rising Clk edge where valid && ready.
// The sender holds data (and valid) stable until that edge; ready may be
// driven independently of valid. flush is a single-cycle pulse with no
// handshake of its own.
interface enc_block_gearbox_if #(
    parameter int BLK_W = enc_pkg::PLAIN_W,
    parameter int IN_W  = enc_pkg::IN_W
) ();

    logic [IN_W-1:0]  in_data;
    logic             in_valid;
    logic             in_ready;
    logic             flush;
    logic [BLK_W-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    // Gearbox side: consumes bytes, produces blocks
    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, out_data, out_valid
    );

    // Environment side: produces bytes, consumes blocks
    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, out_data, out_valid
    );

endinterface

// File: rtl/enc_block_gearbox.sv
// Packs a byte stream MSB-first into BLK_W-bit plaintext blocks for the
// encrypter. A flush pulse drains any partial block.
// Build option ENC_GEARBOX_PAD_EN: when defined, a flushed residue is emitted
// as a zero-padded block; when undefined, the residue is discarded.
module enc_block_gearbox #(
    parameter int BLK_W = enc_pkg::PLAIN_W,
    parameter int IN_W  = enc_pkg::IN_W
) (
    input  logic                      Clk,
    input  logic                      Rst_n,
    enc_block_gearbox_if.slave        bus,
    output logic [$clog2(BLK_W)-1:0]  fill_lvl,
    output logic                      busy,
    output enc_pkg::gb_state_t        state_dbg
);

    import enc_pkg::*;

    localparam int FILL_W = $clog2(BLK_W);
    // Wide enough for fill + IN_W, which peaks at BLK_W + IN_W - 1
    localparam int SUM_W  = $clog2(BLK_W + IN_W);
    localparam logic [SUM_W-1:0] BLK_S = SUM_W'(BLK_W);
    localparam logic [SUM_W-1:0] IN_S  = SUM_W'(IN_W);

    gb_state_t         state;
    logic [BLK_W-1:0]  acc;       // residue, MSB-aligned, zero below fill
    logic [FILL_W-1:0] fill;
    logic [BLK_W-1:0]  out_q;
    logic              out_v;

    logic              free;
    logic              accept;
    logic [SUM_W-1:0]  sum;
    logic [SUM_W-1:0]  spill_sh;
    logic [BLK_W-1:0]  byte_al;
    logic [BLK_W-1:0]  acc_merged;
    logic [BLK_W-1:0]  spill;
    logic              completes;
    logic [FILL_W-1:0] fill_after;

    // Output register can take a new block if empty or being popped now
    assign free         = !out_v || bus.out_ready;
    assign bus.in_ready = Rst_n && free && (state == ACCUM);
    assign accept       = bus.in_valid && bus.in_ready;

    // Packing datapath: merge the incoming byte below the residue, and
    // compute the leftover bits when the byte completes a block
    always_comb begin
        sum        = SUM_W'(fill) + IN_S;
        spill_sh   = BLK_S - SUM_W'(fill);
        byte_al    = BLK_W'(bus.in_data) << (BLK_W - IN_W);
        acc_merged = acc | (byte_al >> fill);
        spill      = byte_al << spill_sh;
        completes  = (sum >= BLK_S);
        fill_after = completes ? FILL_W'(sum - BLK_S) : FILL_W'(sum);
    end

    // Gearbox FSM with accumulator, fill count and output register
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= ACCUM;
            acc   <= '0;
            fill  <= '0;
            out_q <= '0;
            out_v <= 1'b0;
        end else begin
            if (out_v && bus.out_ready) begin
                out_v <= 1'b0;
            end
            unique case (state)
                ACCUM: begin
                    if (accept) begin
                        if (completes) begin
                            out_q <= acc_merged;
                            out_v <= 1'b1;
                            acc   <= spill;
                        end else begin
                            acc   <= acc_merged;
                        end
                        fill <= fill_after;
                        // Byte is packed first; flush then acts on what is left
                        if (bus.flush && (fill_after != '0)) begin
                            state <= FLUSH;
                        end
                    end else if (bus.flush && (fill != '0)) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
`ifdef ENC_GEARBOX_PAD_EN
                    // acc is already zero below the residue, so it is the padded block
                    if (free) begin
                        out_q <= acc;
                        out_v <= 1'b1;
                        acc   <= '0;
                        fill  <= '0;
                        state <= ACCUM;
                    end
`else
                    acc   <= '0;
                    fill  <= '0;
                    state <= ACCUM;
`endif
                end
                default: state <= ACCUM;
            endcase
        end
    end

    assign bus.out_data  = out_q;
    assign bus.out_valid = out_v;
    assign fill_lvl      = fill;
    assign busy          = (fill != '0) || out_v || (state == FLUSH);
    assign state_dbg     = state;

endmodule

// File: tb/tb_enc_block_gearbox.sv
// Randomised and directed bench for enc_block_gearbox. The reference model
// keeps a queue of individual bits and cuts blocks from it.
module tb_enc_block_gearbox;

    localparam int BLK_W = 60;
    localparam int IN_W  = 8;
    localparam logic [59:0] BLK1 = 60'h010203040506070;
    localparam logic [59:0] BLK2 = 60'h8090A0B0C0D0E0F;

    logic               Clk;
    logic               Rst_n;
    logic [5:0]         fill_lvl;
    logic               busy;
    enc_pkg::gb_state_t state_dbg;

    enc_block_gearbox_if #(.BLK_W(BLK_W), .IN_W(IN_W)) bus ();

    enc_block_gearbox #(.BLK_W(BLK_W), .IN_W(IN_W)) dut (
        .Clk       (Clk),
        .Rst_n     (Rst_n),
        .bus       (bus),
        .fill_lvl  (fill_lvl),
        .busy      (busy),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- scoreboard state ----------------
    int            n_checks = 0;
    int            n_fail   = 0;
    bit            bits_q[$];
    logic [59:0]   exp_q[$];
    logic [59:0]   blk_log[$];
    logic          rnd_ready  = 1'b0;
    logic          hold_ready = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Reference model: append bits MSB-first, cut a block at every BLK_W bits
    task automatic model_byte(input logic [7:0] b);
        logic [59:0] blk;
        for (int i = IN_W - 1; i >= 0; i--) bits_q.push_back(b[i]);
        if (bits_q.size() >= BLK_W) begin
            blk = '0;
            for (int i = 0; i < BLK_W; i++) blk = {blk[58:0], bits_q.pop_front()};
            exp_q.push_back(blk);
        end
    endtask

    task automatic model_flush();
        logic [59:0] blk;
        int n;
        n = bits_q.size();
        if (n != 0) begin
`ifdef ENC_GEARBOX_PAD_EN
            blk = '0;
            for (int i = 0; i < BLK_W; i++) blk = {blk[58:0], (i < n) ? bits_q.pop_front() : 1'b0};
            exp_q.push_back(blk);
`endif
            bits_q.delete();
        end
    endtask

    // out_ready: held or random, changed on the falling edge
    always @(negedge Clk) begin
        bus.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : hold_ready;
    end

    // Monitor: observe transfers at the active edge, before DUT updates land
    always @(posedge Clk) begin
        if (Rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                blk_log.push_back(bus.out_data);
                if (exp_q.size() == 0) check("blk_unexpected", {4'h0, bus.out_data}, 64'h0);
                else check("blk", {4'h0, bus.out_data}, {4'h0, exp_q.pop_front()});
            end
            if (bus.in_valid && bus.in_ready) model_byte(bus.in_data);
            if (bus.flush) model_flush();
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b, input logic fl);
        int t;
        t = 0;
        @(negedge Clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        bus.flush    = 1'b0;
        while (1) begin
            #1;
            if (bus.in_ready) break;
            t++;
            if (t > 500) begin
                check("send_timeout", 64'h1, 64'h0);
                bus.in_valid = 1'b0;
                return;
            end
            @(negedge Clk);
        end
        bus.flush = fl;
        @(posedge Clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic do_flush();
        @(negedge Clk);
        bus.flush = 1'b1;
        @(posedge Clk);
        #1;
        bus.flush = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        @(negedge Clk);
        while (busy && t < 200) begin
            @(negedge Clk);
            t++;
        end
        if (t >= 200) check("idle_timeout", 64'h1, 64'h0);
    endtask

    task automatic send_seq_1_15();
        for (int i = 1; i <= 15; i++) send_byte(8'(i), 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int base;
        Rst_n        = 1'b0;
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge Clk);
        #1;
        check("rst_out_valid", {63'h0, bus.out_valid}, 64'h0);
        check("rst_out_data", {4'h0, bus.out_data}, 64'h0);
        check("rst_fill", {58'h0, fill_lvl}, 64'h0);
        check("rst_in_ready", {63'h0, bus.in_ready}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        @(negedge Clk);
        Rst_n = 1'b1;

        // Scenario 1: 15 bytes, consumer always ready
        base = blk_log.size();
        send_seq_1_15();
        wait_idle();
        check("s1_count", 64'(blk_log.size() - base), 64'd2);
        if (blk_log.size() >= base + 2) begin
            check("s1_blk1", {4'h0, blk_log[base]}, {4'h0, BLK1});
            check("s1_blk2", {4'h0, blk_log[base+1]}, {4'h0, BLK2});
        end
        check("s1_fill", {58'h0, fill_lvl}, 64'h0);

        // Scenario 2: consumer stalls, block 1 must hold and input must stall
        hold_ready = 1'b0;
        base = blk_log.size();
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
        repeat (3) @(negedge Clk);
        #1;
        check("s2_hold_valid", {63'h0, bus.out_valid}, 64'h1);
        check("s2_hold_data", {4'h0, bus.out_data}, {4'h0, BLK1});
        check("s2_in_ready", {63'h0, bus.in_ready}, 64'h0);
        check("s2_fill", {58'h0, fill_lvl}, 64'd4);
        fork
            begin
                repeat (10) @(negedge Clk);
                hold_ready = 1'b1;
            end
        join_none
        for (int i = 9; i <= 15; i++) send_byte(8'(i), 1'b0);
        wait_idle();
        check("s2_count", 64'(blk_log.size() - base), 64'd2);
        if (blk_log.size() >= base + 2) begin
            check("s2_blk1", {4'h0, blk_log[base]}, {4'h0, BLK1});
            check("s2_blk2", {4'h0, blk_log[base+1]}, {4'h0, BLK2});
        end

        // Scenario 3: partial block then flush
        base = blk_log.size();
        send_byte(8'hAB, 1'b0);
        send_byte(8'hCD, 1'b0);
        check("s3_fill_pre", {58'h0, fill_lvl}, 64'd16);
        do_flush();
        wait_idle();
        check("s3_fill", {58'h0, fill_lvl}, 64'h0);
`ifdef ENC_GEARBOX_PAD_EN
        check("s3_count", 64'(blk_log.size() - base), 64'd1);
        if (blk_log.size() > base) check("s3_blk", {4'h0, blk_log[base]}, 64'h0ABCD00000000000);
`else
        check("s3_count", 64'(blk_log.size() - base), 64'd0);
`endif

        // Scenario 4: byte and flush in the same cycle
        base = blk_log.size();
        send_byte(8'hFF, 1'b1);
        wait_idle();
        check("s4_fill", {58'h0, fill_lvl}, 64'h0);
`ifdef ENC_GEARBOX_PAD_EN
        check("s4_count", 64'(blk_log.size() - base), 64'd1);
        if (blk_log.size() > base) check("s4_blk", {4'h0, blk_log[base]}, 64'h0FF0000000000000);
`else
        check("s4_count", 64'(blk_log.size() - base), 64'd0);
`endif

        // Scenario 5: flush with nothing held is a no-op
        base = blk_log.size();
        do_flush();
        #1;
        check("s5_busy", {63'h0, busy}, 64'h0);
        repeat (3) @(negedge Clk);
        check("s5_busy_later", {63'h0, busy}, 64'h0);
        check("s5_count", 64'(blk_log.size() - base), 64'd0);

        // Scenario 6: asynchronous reset mid-stream
        for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b0);
        check("s6_fill_pre", {58'h0, fill_lvl}, 64'd40);
        @(negedge Clk);
        #2;
        Rst_n = 1'b0;
        #1;
        bits_q.delete();
        exp_q.delete();
        check("s6_fill", {58'h0, fill_lvl}, 64'h0);
        check("s6_in_ready", {63'h0, bus.in_ready}, 64'h0);
        check("s6_out_valid", {63'h0, bus.out_valid}, 64'h0);
        check("s6_busy", {63'h0, busy}, 64'h0);
        repeat (2) @(negedge Clk);
        Rst_n = 1'b1;
        base = blk_log.size();
        send_seq_1_15();
        wait_idle();
        check("s6_count", 64'(blk_log.size() - base), 64'd2);
        if (blk_log.size() >= base + 2) begin
            check("s6_blk1", {4'h0, blk_log[base]}, {4'h0, BLK1});
            check("s6_blk2", {4'h0, blk_log[base+1]}, {4'h0, BLK2});
        end

        // Scenario 7: random bytes, gaps, back-pressure and occasional flush
        rnd_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            repeat ($urandom_range(0, 2)) @(negedge Clk);
            send_byte(8'($urandom_range(0, 255)), ($urandom_range(0, 15) == 0));
        end
        rnd_ready  = 1'b0;
        hold_ready = 1'b1;
        begin
            int t;
            t = 0;
            @(negedge Clk);
            while ((exp_q.size() != 0 || bus.out_valid || state_dbg != enc_pkg::ACCUM) && t < 300) begin
                @(negedge Clk);
                t++;
            end
            if (t >= 300) check("drain_timeout", 64'h1, 64'h0);
        end
        check("rnd_exp_empty", 64'(exp_q.size()), 64'h0);
        check("rnd_fill", {58'h0, fill_lvl}, 64'(bits_q.size()));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
